// File: rtl/uart_hex_dump.sv
// uart_hex_dump: reads a word range and sends it as ASCII hex over 8N1.
// Define HEX_DUMP_CRLF_EN for a CR/LF separator instead of a space.
module uart_hex_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef HEX_DUMP_CRLF_EN
  localparam logic       SEP_TWO = 1'b1;
  localparam logic [7:0] SEP0    = 8'h0D;
`else
  localparam logic       SEP_TWO = 1'b0;
  localparam logic [7:0] SEP0    = 8'h20;
`endif
  localparam logic [7:0] SEP1 = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_HEX,
    S_SEP,
    S_FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_a;
  logic [31:0]       word;
  logic [2:0]        nib;
  logic              sep_idx;
  logic [8:0]        frame;
  logic [3:0]        bit_cnt;
  logic [CW-1:0]     clk_cnt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h37 + {4'h0, n};
  endfunction

  // Dump sequencer and serializer; a finished stop bit rolls straight
  // into the next character, separator or read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      end_a     <= '0;
      word      <= '0;
      nib       <= '0;
      sep_idx   <= 1'b0;
      frame     <= '1;
      bit_cnt   <= '0;
      clk_cnt   <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur       <= first_addr;
            end_a     <= last_addr;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= first_addr;
            state     <= S_READ;
          end
        end
        S_READ: state <= S_LATCH;
        S_LATCH: begin
          word    <= {mem_rdata[27:0], 4'h0};
          nib     <= '0;
          sep_idx <= 1'b0;
          tx      <= 1'b0;
          frame   <= {1'b1, hex_char(mem_rdata[31:28])};
          bit_cnt <= '0;
          clk_cnt <= '0;
          state   <= S_HEX;
        end
        S_HEX, S_SEP: begin
          if (clk_cnt != CLK_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              tx      <= frame[0];
              frame   <= {1'b1, frame[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (state == S_HEX && nib != 3'd7) begin
              nib     <= nib + 3'd1;
              word    <= {word[27:0], 4'h0};
              tx      <= 1'b0;
              frame   <= {1'b1, hex_char(word[31:28])};
              bit_cnt <= '0;
            end else if (state == S_HEX) begin
              state   <= S_SEP;
              tx      <= 1'b0;
              frame   <= {1'b1, SEP0};
              bit_cnt <= '0;
            end else if (SEP_TWO && !sep_idx) begin
              sep_idx <= 1'b1;
              tx      <= 1'b0;
              frame   <= {1'b1, SEP1};
              bit_cnt <= '0;
            end else if (cur == end_a) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cur       <= cur + 1'b1;
              mem_addr  <= cur + 1'b1;
              mem_rd_en <= 1'b1;
              state     <= S_READ;
            end
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_dump.sv
// tb_uart_hex_dump: random and directed dumps against a byte/wave model.
// Build with or without HEX_DUMP_CRLF_EN to match the design.
module tb_uart_hex_dump;

  localparam int CPB = 4;
  localparam int AW  = 4;
`ifdef HEX_DUMP_CRLF_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int FR = 10 * CPB;
  localparam int W  = 2 + FR * (8 + S);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          tx;
  logic          busy;
  logic          done;

  logic [31:0]   mem [16];
  int            n_checks = 0;
  int            n_fail = 0;
  int            epoch = 0;
  int            frame_err = 0;
  byte unsigned  rx_q[$];
  int            rd_q[$];
  byte unsigned  exp_b[$];
  int            exp_a[$];

  always #5 clk = ~clk;

  uart_hex_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx(tx), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_q.push_back(int'(mem_addr));
    end
  end

  always @(negedge rst_n) epoch++;

  initial begin : mon
    int ep;
    logic [7:0] b;
    logic sb;
    logic st;
    forever begin
      @(negedge tx);
      if (rst_n) begin
        ep = epoch;
        repeat (2) @(posedge clk);
        #1 sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 b[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1 st = tx;
        if (ep == epoch && rst_n) begin
          rx_q.push_back(b);
          if (sb !== 1'b0 || st !== 1'b1) frame_err++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int f, input int l);
    int a;
    logic [31:0] w;
    int nb;
    exp_b.delete();
    exp_a.delete();
    a = f;
    for (int g = 0; g < 16; g++) begin
      exp_a.push_back(a);
      w = mem[a];
      for (int i = 7; i >= 0; i--) begin
        nb = int'((w >> (4 * i)) & 32'hF);
        if (nb < 10) exp_b.push_back(8'(8'h30 + nb));
        else         exp_b.push_back(8'(8'h41 + nb - 10));
      end
      if (S == 2) begin
        exp_b.push_back(8'h0D);
        exp_b.push_back(8'h0A);
      end else begin
        exp_b.push_back(8'h20);
      end
      if (a == l) break;
      a = (a + 1) % 16;
    end
  endfunction

  function automatic logic exp_tx(input int k);
    int j, off, f, bp;
    byte unsigned b;
    j   = (k - 1) / W;
    off = (k - 1) % W;
    if (off < 2) return 1'b1;
    f  = (off - 2) / FR;
    bp = ((off - 2) % FR) / CPB;
    b  = exp_b[j * (8 + S) + f];
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return b[bp - 1];
  endfunction

  task automatic run_dump(input int f, input int l, input int poke_k);
    int n, d;
    int wave_err, busy_err, done_err, rd_err, byte_err, addr_err;
    model(f, l);
    n = exp_a.size();
    d = n * W + 1;
    wave_err = 0; busy_err = 0; done_err = 0;
    rd_err = 0; byte_err = 0; addr_err = 0;
    repeat (2) @(negedge clk);
    rx_q.delete();
    rd_q.delete();
    frame_err = 0;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_addr = AW'($urandom);
    last_addr  = AW'($urandom);
    for (int k = 1; k <= d; k++) begin
      start = (k == poke_k);
      if (k < d) begin
        if (tx !== exp_tx(k)) wave_err++;
        if (busy !== 1'b1) busy_err++;
        if (done !== 1'b0) done_err++;
        if ((k - 1) % W == 0) begin
          if (mem_rd_en !== 1'b1 ||
              int'(mem_addr) != exp_a[(k - 1) / W]) rd_err++;
        end else if (mem_rd_en !== 1'b0) begin
          rd_err++;
        end
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        check("tx_idle_end", 32'(tx), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_once", 32'(done), 32'd0);
    check("tx_wave", 32'(wave_err), 32'd0);
    check("busy_hold", 32'(busy_err), 32'd0);
    check("done_early", 32'(done_err), 32'd0);
    check("rd_timing", 32'(rd_err), 32'd0);
    check("rx_count", 32'(rx_q.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
      if (rx_q[i] != exp_b[i]) byte_err++;
    check("rx_bytes", 32'(byte_err), 32'd0);
    check("rd_count", 32'(rd_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++)
      if (rd_q[i] != exp_a[i]) addr_err++;
    check("rd_order", 32'(addr_err), 32'd0);
    check("framing", 32'(frame_err), 32'd0);
  endtask

  task automatic reset_abort();
    int bad_done, bad_busy, bad_tx;
    bad_done = 0; bad_busy = 0; bad_tx = 0;
    repeat (2) @(negedge clk);
    first_addr = 4'd5;
    last_addr  = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_char_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) bad_done++;
      if (busy !== 1'b0) bad_busy++;
      if (tx !== 1'b1) bad_tx++;
    end
    check("rst_no_done", 32'(bad_done), 32'd0);
    check("rst_idle_busy", 32'(bad_busy), 32'd0);
    check("rst_idle_tx", 32'(bad_tx), 32'd0);
    rx_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int f, l;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    mem[3] = 32'h1234ABCD;
    run_dump(3, 3, -1);

    mem[0] = 32'h00000000;
    mem[1] = 32'hFFFFFFFF;
    mem[2] = 32'hDEADBEEF;
    run_dump(0, 2, -1);

    run_dump(14, 1, -1);

    run_dump(0, 1, 100);
    run_dump(7, 8, 5);
    run_dump(2, 2, -1);

    reset_abort();
    run_dump(9, 9, -1);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      f = int'($urandom_range(0, 15));
      l = (f + int'($urandom_range(0, 2))) % 16;
      run_dump(f, l, int'($urandom_range(1, 300)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
